// File: rtl/serial_comparator.sv
// serial_comparator: compares two unsigned operands streamed MSB first, one
// bit pair per accepted cycle, and reports equal/less/greater with a one-cycle
// done pulse.
// Optional feature: define SERIAL_COMPARE_EARLY_EXIT_EN to finish as soon as
// the first differing bit pair is consumed. By default all input_size pairs
// are always consumed, so latency is fixed.
module serial_comparator #(
  parameter int input_size = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic bit_a,
  input  logic bit_b,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic equal,
  output logic less,
  output logic greater
);

  localparam int cnt_w = $clog2(input_size + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(input_size - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] cnt;
  logic             decided;
  logic             rel_gt;

  logic consume_s;
  logic differ_s;
  logic finish_s;
  logic final_eq_s;
  logic final_gt_s;

  // Decode the consume event, completion condition and final relation
  always_comb begin
    consume_s  = 1'b0;
    differ_s   = bit_a ^ bit_b;
    finish_s   = 1'b0;
    final_eq_s = 1'b0;
    final_gt_s = 1'b0;
    // a start in RUN restarts the comparison, so that cycle's pair is dropped
    if (state == RUN) begin
      consume_s = bit_valid & ~start;
    end else begin
      consume_s = 1'b0;
    end
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    finish_s = consume_s & ((cnt == last_cnt) | (~decided & differ_s));
`else
    finish_s = consume_s & (cnt == last_cnt);
`endif
    // the pair being consumed now still counts if nothing was decided yet
    if (decided) begin
      final_eq_s = 1'b0;
      final_gt_s = rel_gt;
    end else begin
      final_eq_s = ~differ_s;
      final_gt_s = differ_s & bit_a;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      decided   <= 1'b0;
      rel_gt    <= 1'b0;
      bit_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      equal     <= 1'b0;
      less      <= 1'b0;
      greater   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            decided   <= 1'b0;
            rel_gt    <= 1'b0;
            bit_ready <= 1'b1;
            busy      <= 1'b1;
          end else begin
            bit_ready <= 1'b0;
            busy      <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            cnt     <= '0;
            decided <= 1'b0;
            rel_gt  <= 1'b0;
          end else if (consume_s) begin
            cnt <= cnt + cnt_w'(1);
            if (!decided && differ_s) begin
              decided <= 1'b1;
              rel_gt  <= bit_a;
            end else begin
              decided <= decided;
            end
            if (finish_s) begin
              state     <= DONE;
              bit_ready <= 1'b0;
              done      <= 1'b1;
              equal     <= final_eq_s;
              greater   <= ~final_eq_s & final_gt_s;
              less      <= ~final_eq_s & ~final_gt_s;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          // start is deliberately ignored here
          state     <= IDLE;
          bit_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bit_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Testbench for serial_comparator: table-driven directed cases, randomized
// transactions checked against an integer-comparison reference model, and
// hand-written abort/reset/width-1 sequences.
module tb_serial_comparator;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, start, bit_valid, bit_a, bit_b;
  logic bit_ready, busy, done, equal, less, greater;

  logic s1_start, s1_valid, s1_a, s1_b;
  logic r1_ready, r1_busy, r1_done, r1_equal, r1_less, r1_greater;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_comparator #(.input_size(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .bit_a(bit_a), .bit_b(bit_b), .bit_ready(bit_ready), .busy(busy),
    .done(done), .equal(equal), .less(less), .greater(greater)
  );

  serial_comparator #(.input_size(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .bit_valid(s1_valid),
    .bit_a(s1_a), .bit_b(s1_b), .bit_ready(r1_ready), .busy(r1_busy),
    .done(r1_done), .equal(r1_equal), .less(r1_less), .greater(r1_greater)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           stall_at;
    int           stall_len;
    logic [2:0]   exp_flags; // {equal, less, greater}
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pairs consumed before completion: all of them, or up to the first
  // differing bit (MSB first) when early exit is built in.
  function automatic int exp_consumed(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return N - i;
    end
`endif
    return N;
  endfunction

  // One full comparison: start pulse, stream bits (optionally stalling),
  // wait for done and check result, latency and post-done behaviour.
  task automatic run_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int stall_at, input int stall_len, input bit rand_gaps,
                         input logic [2:0] exp_flags);
    int idx = 0;
    int stalled = 0;
    int consumed = 0;
    int done_cyc = -1;
    int last_cyc = -1;
    bit seen = 1'b0;
    logic [2:0] got_flags = 3'b000;
    @(negedge clk);
    // a differing pair in the start cycle must not be consumed
    start = 1'b1; bit_valid = 1'b1; bit_a = 1'b0; bit_b = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cyc  = c;
        got_flags = {equal, less, greater};
        seen      = 1'b1;
        break;
      end
      if (!rand_gaps && idx == stall_at && stalled < stall_len) begin
        bit_valid = 1'b0;
        stalled++;
      end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
        bit_valid = 1'b0;
      end else if (idx < N) begin
        bit_valid = 1'b1;
        bit_a = a[N-1-idx];
        bit_b = b[N-1-idx];
      end else begin
        bit_valid = 1'b0;
      end
      if (bit_valid && bit_ready) begin
        idx++;
        consumed++;
        last_cyc = c;
      end
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " flags"}, got_flags, exp_flags);
    check({tag, " consumed"}, consumed, exp_consumed(a, b));
    check({tag, " latency"}, done_cyc, last_cyc + 1);
    if (!rand_gaps && stall_len > 0) begin
      check({tag, " stall_delay"}, done_cyc, exp_consumed(a, b) + stall_len);
    end
    // start during DONE is ignored: the block still returns to idle
    start = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " flags_hold"}, {equal, less, greater}, exp_flags);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [2:0] mflags;
    int bad;

    vecs[0] = '{a: 8'h5A, b: 8'h5A, stall_at: -1, stall_len: 0, exp_flags: 3'b100};
    vecs[1] = '{a: 8'h80, b: 8'h7F, stall_at: -1, stall_len: 0, exp_flags: 3'b001};
    vecs[2] = '{a: 8'h10, b: 8'h11, stall_at: 4,  stall_len: 3, exp_flags: 3'b010};
    vecs[3] = '{a: 8'h00, b: 8'hFF, stall_at: -1, stall_len: 0, exp_flags: 3'b010};
    vecs[4] = '{a: 8'hFF, b: 8'hFE, stall_at: -1, stall_len: 0, exp_flags: 3'b001};
    vecs[5] = '{a: 8'h00, b: 8'h00, stall_at: 2,  stall_len: 2, exp_flags: 3'b100};

    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    s1_start = 1'b0; s1_valid = 1'b0; s1_a = 1'b0; s1_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {bit_ready, busy, done, equal, less, greater}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset idle", {bit_ready, busy, done, equal, less, greater}, 0);

    // directed table
    for (int i = 0; i < 6; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].stall_at,
              vecs[i].stall_len, 1'b0, vecs[i].exp_flags);
    end

    // randomized transactions against the integer reference model
    for (int t = 0; t < 20; t++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
      mflags = {ra == rb, ra < rb, ra > rb};
      run_cmp($sformatf("rand%0d", t), ra, rb, -1, 0, 1'b1, mflags);
    end

    // abort: 5 pairs consumed, then restart with A=FF, B=00
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || !bit_ready) bad++;
      bit_valid = 1'b1;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
      bit_a = 1'b1; bit_b = 1'b1;
`else
      bit_a = 1'b0; bit_b = 1'b1;
`endif
    end
    check("abort no early done", bad, 0);
    run_cmp("abort restart", 8'hFF, 8'h00, -1, 0, 1'b0, 3'b001);

    // reset mid-comparison after 3 pairs
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; bit_a = 1'b1; bit_b = 1'b1;
    end
    @(negedge clk);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async reset outputs", {bit_ready, busy, done, equal, less, greater}, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({busy, done, equal, less, greater} != 5'b00000) bad++;
    end
    check("flags stay 0 after reset", bad, 0);
    run_cmp("after reset", 8'h3C, 8'h3D, -1, 0, 1'b0, 3'b010);

    // input_size = 1 instance
    for (int k = 0; k < 3; k++) begin
      logic [1:0] pair;
      logic [2:0] e1;
      pair = (k == 0) ? 2'b10 : ((k == 1) ? 2'b01 : 2'b11);
      e1 = {pair[1] == pair[0], pair[1] < pair[0], pair[1] > pair[0]};
      @(negedge clk);
      s1_start = 1'b1; s1_valid = 1'b0;
      @(negedge clk);
      s1_start = 1'b0;
      check($sformatf("w1 ready %0d", k), r1_ready, 1);
      s1_valid = 1'b1; s1_a = pair[1]; s1_b = pair[0];
      @(negedge clk);
      s1_valid = 1'b0;
      check($sformatf("w1 done %0d", k), r1_done, 1);
      check($sformatf("w1 flags %0d", k), {r1_equal, r1_less, r1_greater}, e1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
